// File: rtl/am_pkg.sv
// rtl/am_pkg.sv - shared constants, lane marker encodings and BIP-8 parity for the TX alignment-marker inserter
package am_pkg;

  localparam int BLOCK_W = 66;
  localparam int BIP_W = 8;
  localparam logic [1:0] SYNC_HEAD_CTRL = 2'b10;

  // Per-lane marker bytes M0, M1, M2; AM_ENC[lane][0] is M0.
  localparam logic [0:3][0:2][7:0] AM_ENC = {
    8'h90, 8'h76, 8'h47,
    8'hF0, 8'hC4, 8'hE6,
    8'hC5, 8'h65, 8'h9B,
    8'hA2, 8'h79, 8'h3D
  };

  // Payload bit i lands in BIP bit (i-2)%8; sync header bits fold into BIP bits 3 and 4.
  function automatic logic [BIP_W-1:0] bip_par(input logic [BLOCK_W-1:0] blk);
    logic [BIP_W-1:0] p;
    p = '0;
    for (int b = 0; b < 8; b++) begin
      p = p ^ blk[2 + 8*b +: 8];
    end
    p[3] = p[3] ^ blk[0];
    p[4] = p[4] ^ blk[1];
    return p;
  endfunction

endpackage

// File: rtl/am_bip_lane.sv
// rtl/am_bip_lane.sv - per-lane BIP-8 accumulator and alignment-marker block builder
module am_bip_lane
  import am_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               i_mark,
  input  logic               i_accept,
  input  logic               i_err,
  input  logic [BLOCK_W-1:0] i_block,
  input  logic [0:2][7:0]    i_enc,
  output logic [BLOCK_W-1:0] o_marker
);

  logic [BIP_W-1:0] r_bip;
  logic [BIP_W-1:0] w_bip3;

  // Only BIP3 carries an injected error; BIP7 always reflects the true accumulator.
  assign w_bip3 = r_bip ^ {{(BIP_W-1){1'b0}}, i_err};

  assign o_marker = {~r_bip, ~i_enc[2], ~i_enc[1], ~i_enc[0],
                     w_bip3, i_enc[2], i_enc[1], i_enc[0], SYNC_HEAD_CTRL};

  // A marker restarts the accumulator with its own parity as emitted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bip <= '0;
    end else if (i_mark) begin
      r_bip <= bip_par(o_marker);
    end else if (i_accept) begin
      r_bip <= r_bip ^ bip_par(i_block);
    end
  end

endmodule

// File: rtl/am_insert_tx.sv
// rtl/am_insert_tx.sv - multi-lane 40GBASE-R TX alignment-marker inserter; AM_TX_BIP_ERR_INJ_EN adds bip_err_i
module am_insert_tx
  import am_pkg::*;
#(
  parameter int NLANE  = 4,
  parameter int HEAD_W = 2,
  parameter int DATA_W = 64,
  parameter int GAP    = 16383,
  parameter int CNT_W  = $clog2(GAP + 1)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             in_v,
  output logic                             in_ready,
  input  logic [NLANE*(HEAD_W+DATA_W)-1:0] in_data,
`ifdef AM_TX_BIP_ERR_INJ_EN
  input  logic [NLANE-1:0]                 bip_err_i,
`endif
  output logic                             out_v,
  output logic                             out_marker,
  output logic [NLANE*(HEAD_W+DATA_W)-1:0] out_data
);

  localparam int LW = HEAD_W + DATA_W;

  logic [CNT_W-1:0]    r_cnt;
  logic                r_out_v;
  logic                r_out_marker;
  logic [NLANE*LW-1:0] r_out_data;

  logic                w_mark;
  logic                w_accept;
  logic [NLANE-1:0]    w_err;
  logic [NLANE*LW-1:0] w_marker;

  assign w_mark   = (r_cnt == CNT_W'(GAP));
  assign in_ready = ~w_mark;
  assign w_accept = in_v & ~w_mark;

`ifdef AM_TX_BIP_ERR_INJ_EN
  assign w_err = bip_err_i;
`else
  assign w_err = '0;
`endif

  for (genvar l = 0; l < NLANE; l++) begin : g_lane
    am_bip_lane u_lane (
      .clk      (clk),
      .reset    (reset),
      .i_mark   (w_mark),
      .i_accept (w_accept),
      .i_err    (w_err[l]),
      .i_block  (in_data[l*LW +: LW]),
      .i_enc    (AM_ENC[l]),
      .o_marker (w_marker[l*LW +: LW])
    );
  end

  // Reset leaves the counter at GAP so the very first output is a marker.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt        <= CNT_W'(GAP);
      r_out_v      <= 1'b0;
      r_out_marker <= 1'b0;
      r_out_data   <= '0;
    end else if (w_mark) begin
      r_cnt        <= '0;
      r_out_v      <= 1'b1;
      r_out_marker <= 1'b1;
      r_out_data   <= w_marker;
    end else if (in_v) begin
      r_cnt        <= r_cnt + CNT_W'(1);
      r_out_v      <= 1'b1;
      r_out_marker <= 1'b0;
      r_out_data   <= in_data;
    end else begin
      r_out_v      <= 1'b0;
      r_out_marker <= 1'b0;
    end
  end

  assign out_v      = r_out_v;
  assign out_marker = r_out_marker;
  assign out_data   = r_out_data;

endmodule

// File: tb/tb_am_insert_tx.sv
// tb/tb_am_insert_tx.sv - scoreboard bench for am_insert_tx with NLANE=4, GAP=4
module tb_am_insert_tx;

  localparam int NL = 4;
  localparam int G  = 4;
  localparam int BW = 66;

  typedef struct {
    logic             v;
    logic             mk;
    logic [NL*BW-1:0] d;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             in_v = 1'b0;
  logic [NL*BW-1:0] in_data = '0;
  logic [NL-1:0]    bip_err_i = '0;
  logic             in_ready;
  logic             out_v;
  logic             out_marker;
  logic [NL*BW-1:0] out_data;

  int checks = 0;
  int errors = 0;

  int               m_cnt;
  logic [7:0]       m_bip [NL];
  logic [NL*BW-1:0] m_out;
  exp_t             q [$];

  logic [7:0] enc_t [NL][3] = '{'{8'h90, 8'h76, 8'h47}, '{8'hF0, 8'hC4, 8'hE6},
                                '{8'hC5, 8'h65, 8'h9B}, '{8'hA2, 8'h79, 8'h3D}};

  always #5 clk = ~clk;

  am_insert_tx #(.NLANE(NL), .HEAD_W(2), .DATA_W(64), .GAP(G)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_v       (in_v),
    .in_ready   (in_ready),
    .in_data    (in_data),
`ifdef AM_TX_BIP_ERR_INJ_EN
    .bip_err_i  (bip_err_i),
`endif
    .out_v      (out_v),
    .out_marker (out_marker),
    .out_data   (out_data)
  );

  function automatic logic [7:0] ref_par(input logic [65:0] b);
    logic [7:0] p;
    p = '0;
    for (int i = 2; i < 66; i++) p[(i-2)%8] = p[(i-2)%8] ^ b[i];
    p[3] = p[3] ^ b[0];
    p[4] = p[4] ^ b[1];
    return p;
  endfunction

  function automatic logic [65:0] ref_marker(input int l, input logic [7:0] bip, input logic e);
    logic [65:0] b;
    b[1:0]   = 2'b10;
    b[9:2]   = enc_t[l][0];
    b[17:10] = enc_t[l][1];
    b[25:18] = enc_t[l][2];
    b[33:26] = bip ^ {7'b0, e};
    b[41:34] = ~enc_t[l][0];
    b[49:42] = ~enc_t[l][1];
    b[57:50] = ~enc_t[l][2];
    b[65:58] = ~bip;
    return b;
  endfunction

  function automatic logic [NL*BW-1:0] all_lanes(input logic [63:0] base, input logic [1:0] hdr, input bit seq);
    logic [NL*BW-1:0] d;
    for (int l = 0; l < NL; l++) d[l*BW +: BW] = {seq ? base + 64'(l) : base, hdr};
    return d;
  endfunction

  task automatic model_reset();
    m_cnt = G;
    for (int l = 0; l < NL; l++) m_bip[l] = 8'h00;
    m_out = '0;
    q.delete();
  endtask

  // Called at a negedge; drives one cycle, scores the registered result, returns at the next negedge.
  task automatic step(input logic v, input logic [NL*BW-1:0] d, input logic [NL-1:0] e,
                      output logic rdy, output logic mk);
    exp_t x;
    exp_t got;
    logic [65:0] lm;
    in_v = v;
    in_data = d;
    bip_err_i = e;
    #1;
    rdy = in_ready;
    checks++;
    if (in_ready !== (m_cnt != G)) begin
      errors++;
      $display("FAIL in_ready: got %b expected %b", in_ready, (m_cnt != G));
    end
    if (m_cnt == G) begin
      for (int l = 0; l < NL; l++) begin
`ifdef AM_TX_BIP_ERR_INJ_EN
        lm = ref_marker(l, m_bip[l], e[l]);
`else
        lm = ref_marker(l, m_bip[l], 1'b0);
`endif
        m_out[l*BW +: BW] = lm;
        m_bip[l] = ref_par(lm);
      end
      x.v = 1'b1; x.mk = 1'b1; m_cnt = 0;
    end else if (v) begin
      for (int l = 0; l < NL; l++) m_bip[l] = m_bip[l] ^ ref_par(d[l*BW +: BW]);
      m_out = d;
      x.v = 1'b1; x.mk = 1'b0; m_cnt++;
    end else begin
      x.v = 1'b0; x.mk = 1'b0;
    end
    x.d = m_out;
    q.push_back(x);
    @(posedge clk);
    #1;
    checks++;
    if (q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard: queue empty at output");
    end else begin
      got = q.pop_front();
      if (out_v !== got.v || out_marker !== got.mk || out_data !== got.d) begin
        errors++;
        $display("FAIL output: got v=%b mk=%b d=%h expected v=%b mk=%b d=%h",
                 out_v, out_marker, out_data, got.v, got.mk, got.d);
      end
    end
    mk = out_marker;
    @(negedge clk);
  endtask

  task automatic check_bip_fields(input string name, input int l, input logic [7:0] b3, input logic [7:0] b7);
    checks++;
    if (out_data[l*BW+26 +: 8] !== b3 || out_data[l*BW+58 +: 8] !== b7) begin
      errors++;
      $display("FAIL %s lane%0d: got BIP3=%h BIP7=%h expected BIP3=%h BIP7=%h",
               name, l, out_data[l*BW+26 +: 8], out_data[l*BW+58 +: 8], b3, b7);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (out_v !== 1'b0 || out_marker !== 1'b0 || out_data !== '0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got v=%b mk=%b rdy=%b d=%h expected 0 0 0 0", out_v, out_marker, in_ready, out_data);
    end
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_first_marker();
    logic rdy, mk;
    logic [65:0] exp_l0;
    exp_l0 = {8'hFF, 8'hB8, 8'h89, 8'h6F, 8'h00, 8'h47, 8'h76, 8'h90, 2'b10};
    step(1'b0, '0, '0, rdy, mk);
    checks++;
    if (mk !== 1'b1 || rdy !== 1'b0 || out_data[65:0] !== exp_l0) begin
      errors++;
      $display("FAIL first_marker: got mk=%b rdy=%b lane0=%h expected 1 0 %h", mk, rdy, out_data[65:0], exp_l0);
    end
    step(1'b0, '0, '0, rdy, mk);
    checks++;
    if (rdy !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_marker: got %b expected 1", rdy);
    end
  endtask

  task automatic test_bip_zero();
    logic rdy, mk;
    for (int i = 0; i < 4; i++) step(1'b1, all_lanes(64'h0, 2'b01, 0), '0, rdy, mk);
    step(1'b0, '0, '0, rdy, mk);
    for (int l = 0; l < NL; l++) check_bip_fields("bip_zero", l, 8'h10, 8'hEF);
  endtask

  task automatic test_bip_one();
    logic rdy, mk;
    for (int i = 0; i < 3; i++) step(1'b1, all_lanes(64'h0, 2'b01, 0), '0, rdy, mk);
    step(1'b1, all_lanes(64'h1, 2'b01, 0), '0, rdy, mk);
    step(1'b0, '0, '0, rdy, mk);
    for (int l = 0; l < NL; l++) check_bip_fields("bip_one", l, 8'h11, 8'hEE);
  endtask

  task automatic test_back_to_back();
    logic rdy, mk;
    int k, lows, marks, bad;
    k = 0; lows = 0; marks = 0; bad = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b1, all_lanes(64'(k * NL + 64'h100), 2'b01, 1), '0, rdy, mk);
      if (rdy) k++;
      else lows++;
      if (mk) marks++;
      if ((rdy == 1'b0) != (i % 5 == 4) || mk != (i % 5 == 4)) bad++;
    end
    checks++;
    if (lows != 4 || marks != 4 || bad != 0 || k != 16) begin
      errors++;
      $display("FAIL back_to_back: got lows=%0d marks=%0d bad=%0d accepted=%0d expected 4 4 0 16", lows, marks, bad, k);
    end
  endtask

  task automatic test_toggle();
    logic rdy, mk;
    logic [8:0] pat, seen;
    pat = 9'b0_1101_1001;
    seen = '0;
    for (int i = 0; i < 9; i++) begin
      step(pat[i], all_lanes(64'(i * 16), 2'b01, 1), '0, rdy, mk);
      seen[i] = mk;
    end
    checks++;
    if (seen !== 9'b0_1000_0000) begin
      errors++;
      $display("FAIL toggle_marker_pos: got %b expected %b", seen, 9'b0_1000_0000);
    end
  endtask

  task automatic test_async_reset();
    logic rdy, mk;
    logic [NL-1:0] inj;
`ifdef AM_TX_BIP_ERR_INJ_EN
    inj = 4'b0100;
`else
    inj = 4'b0000;
`endif
    step(1'b1, all_lanes(64'hABCD, 2'b01, 1), '0, rdy, mk);
    step(1'b1, all_lanes(64'h1234, 2'b10, 1), '0, rdy, mk);
    #1 reset = 1'b1;
    #1;
    checks++;
    if (out_v !== 1'b0 || out_marker !== 1'b0 || out_data !== '0) begin
      errors++;
      $display("FAIL async_reset: got v=%b mk=%b d=%h expected 0 0 0", out_v, out_marker, out_data);
    end
    #1 reset = 1'b0;
    model_reset();
    step(1'b0, '0, inj, rdy, mk);
    for (int l = 0; l < NL; l++)
      check_bip_fields("post_reset", l, inj[l] ? 8'h01 : 8'h00, 8'hFF);
    for (int i = 0; i < 4; i++) step(1'b1, all_lanes(64'(i * 3 + 7), 2'b01, 1), '0, rdy, mk);
    step(1'b0, '0, '0, rdy, mk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_first_marker();
    test_bip_zero();
    test_bip_one();
    test_back_to_back();
    test_toggle();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
